// File: rtl/map_table_ckpt.sv
// map_table_ckpt: superscalar register map table (tag + t_plus per arch register)
// with a circular queue of live branch checkpoints for single-cycle recovery.
module map_table_ckpt #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int CDB_WIDTH      = 2,
    parameter int RETIRE_WIDTH   = 2,
    parameter int NUM_CKPT       = 4,
    parameter int TAG_W          = 5,
    localparam int IW            = $clog2(NUM_CKPT)
) (
    input  logic                            clock_i,
    input  logic                            reset_n_i,
    input  logic [DISPATCH_WIDTH-1:0]       dp_valid_i,
    input  logic [DISPATCH_WIDTH-1:0]       dp_has_dest_i,
    input  logic [DISPATCH_WIDTH*5-1:0]     dp_dest_idx_i,
    input  logic [DISPATCH_WIDTH*TAG_W-1:0] dp_tag_i,
    input  logic [DISPATCH_WIDTH-1:0]       dp_is_branch_i,
    input  logic [DISPATCH_WIDTH-1:0]       dp_rs1_valid_i,
    input  logic [DISPATCH_WIDTH-1:0]       dp_rs2_valid_i,
    input  logic [DISPATCH_WIDTH*5-1:0]     dp_rs1_idx_i,
    input  logic [DISPATCH_WIDTH*5-1:0]     dp_rs2_idx_i,
    input  logic [CDB_WIDTH-1:0]            cdb_valid_i,
    input  logic [CDB_WIDTH*TAG_W-1:0]      cdb_tag_i,
    input  logic [RETIRE_WIDTH-1:0]         rt_valid_i,
    input  logic [RETIRE_WIDTH*TAG_W-1:0]   rt_tag_i,
    input  logic                            br_valid_i,
    input  logic [IW-1:0]                   br_ckpt_i,
    input  logic                            br_mispredict_i,
    output logic [DISPATCH_WIDTH*TAG_W-1:0] rs1_tag_o,
    output logic [DISPATCH_WIDTH*TAG_W-1:0] rs2_tag_o,
    output logic [DISPATCH_WIDTH-1:0]       rs1_ready_o,
    output logic [DISPATCH_WIDTH-1:0]       rs2_ready_o,
    output logic [IW-1:0]                   ckpt_id_o,
    output logic                            ckpt_full_o,
    output logic [IW:0]                     ckpt_count_o,
    output logic [32*(TAG_W+1)-1:0]         m_table_dbg_o
);
    localparam int E = TAG_W + 1;
    typedef logic [E-1:0] ent_t;
    logic [31:0][E-1:0]               tbl_q, tbl_d;
    logic [NUM_CKPT-1:0][31:0][E-1:0] ck_q, ck_d;
    logic [IW-1:0]                    head_q, head_d, tail_q, tail_d;
    logic [IW:0]                      count_q, count_d;
    logic                             mp, rs_ok, full, alloc;

    function automatic logic cdb_hit(input logic [TAG_W-1:0] t);
        cdb_hit = 1'b0;
        for (int i = 0; i < CDB_WIDTH; i++)
            if (t != '0 && cdb_valid_i[i] && cdb_tag_i[i*TAG_W +: TAG_W] == t) cdb_hit = 1'b1;
    endfunction

    function automatic logic rt_hit(input logic [TAG_W-1:0] t);
        rt_hit = 1'b0;
        for (int i = 0; i < RETIRE_WIDTH; i++)
            if (t != '0 && rt_valid_i[i] && rt_tag_i[i*TAG_W +: TAG_W] == t) rt_hit = 1'b1;
    endfunction

    // retire clear takes priority over the CDB ready update
    function automatic ent_t settle(input ent_t e);
        settle = rt_hit(e[E-1:1]) ? '0 : {e[E-1:1], e[0] | cdb_hit(e[E-1:1])};
    endfunction

    function automatic ent_t src(input int k, input logic v, input logic [4:0] s);
        src = '0;
        if (v && s != '0) begin
            src = {tbl_q[s][E-1:1], tbl_q[s][0] | cdb_hit(tbl_q[s][E-1:1])};
            for (int j = 0; j < DISPATCH_WIDTH; j++)
                if (j < k && dp_valid_i[j] && dp_has_dest_i[j] && dp_dest_idx_i[j*5 +: 5] == s)
                    src = {dp_tag_i[j*TAG_W +: TAG_W], 1'b0};
        end
    endfunction

    for (genvar g = 0; g < DISPATCH_WIDTH; g++) begin : g_rd
        assign {rs1_tag_o[g*TAG_W +: TAG_W], rs1_ready_o[g]} = src(g, dp_rs1_valid_i[g], dp_rs1_idx_i[g*5 +: 5]);
        assign {rs2_tag_o[g*TAG_W +: TAG_W], rs2_ready_o[g]} = src(g, dp_rs2_valid_i[g], dp_rs2_idx_i[g*5 +: 5]);
    end

    assign full          = count_q == (IW+1)'(NUM_CKPT);
    assign ckpt_full_o   = full;
    assign ckpt_id_o     = tail_q;
    assign ckpt_count_o  = count_q;
    assign m_table_dbg_o = tbl_q;

    always_comb begin
        mp    = br_valid_i & br_mispredict_i;
        rs_ok = br_valid_i & ~br_mispredict_i;
        alloc = 1'b0;
        for (int i = 0; i < 32; i++) tbl_d[i] = settle(tbl_q[i]);
        for (int c = 0; c < NUM_CKPT; c++)
            for (int i = 0; i < 32; i++) ck_d[c][i] = settle(ck_q[c][i]);
        // lanes applied oldest first so the snapshot sees only lanes up to the branch
        for (int j = 0; j < DISPATCH_WIDTH; j++) begin
            if (!mp && dp_valid_i[j] && dp_has_dest_i[j] && dp_dest_idx_i[j*5 +: 5] != '0)
                tbl_d[dp_dest_idx_i[j*5 +: 5]] = {dp_tag_i[j*TAG_W +: TAG_W], 1'b0};
            if (!mp && !full && dp_valid_i[j] && dp_is_branch_i[j]) begin
                alloc         = 1'b1;
                ck_d[tail_q]  = tbl_d;
            end
        end
        if (mp) tbl_d = ck_d[br_ckpt_i];
        head_d  = head_q + IW'(rs_ok);
        tail_d  = mp ? br_ckpt_i : tail_q + IW'(alloc);
        count_d = mp ? {1'b0, br_ckpt_i - head_q} : count_q + (IW+1)'(alloc) - (IW+1)'(rs_ok);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tbl_q   <= '0;
            ck_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            tbl_q   <= tbl_d;
            ck_q    <= ck_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_map_table_ckpt.sv
// tb_map_table_ckpt: directed vectors and sequences plus randomized traffic
// checked against an array/queue reference model of the map table.
module tb_map_table_ckpt;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       lv[2], lhd[2], lbr[2], r1v[2], r2v[2], cv[2], rv[2];
    logic [4:0] ld[2], lt[2], r1[2], r2[2], ct[2], rtg[2];
    logic       bv, bm;
    logic [1:0] bc;

    logic [9:0]   rs1_tag, rs2_tag;
    logic [1:0]   rs1_ready, rs2_ready, ckpt_id;
    logic         ckpt_full;
    logic [2:0]   ckpt_count;
    logic [191:0] dbg;

    map_table_ckpt dut (
        .clock_i(clk), .reset_n_i(rst_n),
        .dp_valid_i({lv[1], lv[0]}), .dp_has_dest_i({lhd[1], lhd[0]}),
        .dp_dest_idx_i({ld[1], ld[0]}), .dp_tag_i({lt[1], lt[0]}),
        .dp_is_branch_i({lbr[1], lbr[0]}),
        .dp_rs1_valid_i({r1v[1], r1v[0]}), .dp_rs2_valid_i({r2v[1], r2v[0]}),
        .dp_rs1_idx_i({r1[1], r1[0]}), .dp_rs2_idx_i({r2[1], r2[0]}),
        .cdb_valid_i({cv[1], cv[0]}), .cdb_tag_i({ct[1], ct[0]}),
        .rt_valid_i({rv[1], rv[0]}), .rt_tag_i({rtg[1], rtg[0]}),
        .br_valid_i(bv), .br_ckpt_i(bc), .br_mispredict_i(bm),
        .rs1_tag_o(rs1_tag), .rs2_tag_o(rs2_tag),
        .rs1_ready_o(rs1_ready), .rs2_ready_o(rs2_ready),
        .ckpt_id_o(ckpt_id), .ckpt_full_o(ckpt_full), .ckpt_count_o(ckpt_count),
        .m_table_dbg_o(dbg)
    );

    // reference model: plain arrays for table and checkpoints, a queue of live ids
    int m_tag[32], m_rdy[32];
    int c_tag[4][32], c_rdy[4][32];
    int live[$];
    int next_id;
    int pass_n = 0, total_n = 0;

    typedef struct {
        int w0v, w0d, w0t, w1v, w1d, w1t, r1, cdv, cdt, rtv, rtt, e_tag, e_rdy, idx, e_ent;
    } vec_t;
    vec_t vt[13] = '{
        '{1,7,4,  0,0,0,  7, 0,0, 0,0, 4,0, 7, 8},
        '{1,9,4,  1,9,5,  7, 0,0, 0,0, 4,0, 9, 10},
        '{1,3,6,  0,0,0,  0, 0,0, 0,0, 0,0, 3, 12},
        '{0,0,0,  0,0,0,  3, 1,6, 0,0, 6,1, 3, 13},
        '{0,0,0,  0,0,0,  9, 1,0, 0,0, 5,0, 9, 10},
        '{1,4,2,  0,0,0,  4, 0,0, 0,0, 2,0, 4, 4},
        '{1,4,8,  0,0,0,  4, 0,0, 1,2, 8,0, 4, 16},
        '{1,4,2,  0,0,0,  0, 0,0, 0,0, 0,0, 4, 4},
        '{0,0,0,  0,0,0,  4, 0,0, 1,2, 2,0, 4, 0},
        '{0,0,0,  1,0,9,  0, 0,0, 0,0, 0,0, 0, 0},
        '{0,0,0,  0,0,0,  3, 0,0, 0,0, 6,1, 3, 13},
        '{0,0,0,  0,0,0,  3, 1,6, 1,6, 6,1, 3, 0},
        '{0,0,0,  1,9,10, 9, 0,0, 0,0, 5,0, 9, 20}
    };

    task automatic chk(input string nm, input int act, input int exp);
        total_n++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else pass_n++;
    endtask

    function automatic bit retiring(input int t);
        for (int i = 0; i < 2; i++) if (t != 0 && rv[i] && int'(rtg[i]) == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit completing(input int t);
        for (int i = 0; i < 2; i++) if (t != 0 && cv[i] && int'(ct[i]) == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_read(input int k, input bit v, input int s, output int tag, output int rdy);
        tag = 0;
        rdy = 0;
        if (!v || s == 0) return;
        for (int j = k - 1; j >= 0; j--)
            if (lv[j] && lhd[j] && int'(ld[j]) == s) begin
                tag = lt[j];
                return;
            end
        tag = m_tag[s];
        rdy = (m_rdy[s] != 0 || completing(m_tag[s])) ? 1 : 0;
    endfunction

    task automatic model_reset();
        foreach (m_tag[i]) begin m_tag[i] = 0; m_rdy[i] = 0; end
        for (int c = 0; c < 4; c++) for (int i = 0; i < 32; i++) begin c_tag[c][i] = 0; c_rdy[c][i] = 0; end
        live.delete();
        next_id = 0;
    endtask

    task automatic model_edge();
        int nt[32], nr[32];
        int b = -1;
        bit mp = bv && bm;
        bit alloc = 1'b0;
        for (int j = 0; j < 2; j++) if (lv[j] && lbr[j]) b = j;
        assert (mp || b < 0 || live.size() < 4) else $error("protocol: branch offered while checkpoints full");
        for (int i = 0; i < 32; i++) begin
            nt[i] = retiring(m_tag[i]) ? 0 : m_tag[i];
            nr[i] = retiring(m_tag[i]) ? 0 : ((m_rdy[i] != 0 || completing(m_tag[i])) ? 1 : 0);
        end
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 32; i++) begin
                if (retiring(c_tag[c][i])) begin c_tag[c][i] = 0; c_rdy[c][i] = 0; end
                else if (completing(c_tag[c][i])) c_rdy[c][i] = 1;
            end
        if (mp) begin
            nt = c_tag[bc];
            nr = c_rdy[bc];
        end else
            for (int j = 0; j < 2; j++) begin
                if (lv[j] && lhd[j] && ld[j] != 0) begin nt[ld[j]] = lt[j]; nr[ld[j]] = 0; end
                if (j == b && live.size() < 4) begin
                    alloc = 1'b1;
                    c_tag[next_id] = nt;
                    c_rdy[next_id] = nr;
                end
            end
        m_tag = nt;
        m_rdy = nr;
        if (bv && !bm && live.size() > 0) void'(live.pop_front());
        if (alloc) begin live.push_back(next_id); next_id = (next_id + 1) % 4; end
        if (mp) begin
            while (live.size() > 0 && live[$] != int'(bc)) void'(live.pop_back());
            if (live.size() > 0) void'(live.pop_back());
            next_id = bc;
        end
    endtask

    task automatic check_comb();
        int et, er;
        for (int k = 0; k < 2; k++) begin
            model_read(k, r1v[k], r1[k], et, er);
            chk($sformatf("rs1_tag[%0d]", k), rs1_tag[k*5 +: 5], et);
            chk($sformatf("rs1_ready[%0d]", k), rs1_ready[k], er);
            model_read(k, r2v[k], r2[k], et, er);
            chk($sformatf("rs2_tag[%0d]", k), rs2_tag[k*5 +: 5], et);
            chk($sformatf("rs2_ready[%0d]", k), rs2_ready[k], er);
        end
    endtask

    task automatic check_state();
        for (int i = 0; i < 32; i++) chk($sformatf("entry x%0d", i), dbg[i*6 +: 6], m_tag[i] * 2 + m_rdy[i]);
        chk("ckpt_count", ckpt_count, live.size());
        chk("ckpt_full", ckpt_full, live.size() == 4 ? 1 : 0);
        chk("ckpt_id", ckpt_id, next_id);
    endtask

    task automatic clear_in();
        for (int k = 0; k < 2; k++) begin
            lv[k] = 0; lhd[k] = 0; lbr[k] = 0; r1v[k] = 0; r2v[k] = 0; cv[k] = 0; rv[k] = 0;
            ld[k] = 0; lt[k] = 0; r1[k] = 0; r2[k] = 0; ct[k] = 0; rtg[k] = 0;
        end
        bv = 0; bm = 0; bc = 0;
    endtask

    task automatic settle_check(); #2; check_comb(); endtask
    task automatic edge_check(); @(posedge clk); model_edge(); #1; check_state(); endtask
    task automatic cycle(); settle_check(); edge_check(); endtask

    task automatic do_reset();
        clear_in();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic wr(input int k, input int d, input int t);
        lv[k] = 1; lhd[k] = 1; ld[k] = 5'(d); lt[k] = 5'(t);
    endtask

    initial begin
        #1;
        do_reset();
        foreach (vt[n]) begin
            clear_in();
            lv[0] = 1'(vt[n].w0v); lhd[0] = 1'(vt[n].w0v); ld[0] = 5'(vt[n].w0d); lt[0] = 5'(vt[n].w0t);
            lv[1] = 1'(vt[n].w1v); lhd[1] = 1'(vt[n].w1v); ld[1] = 5'(vt[n].w1d); lt[1] = 5'(vt[n].w1t);
            r1v[1] = 1; r1[1] = 5'(vt[n].r1);
            cv[0] = 1'(vt[n].cdv); ct[0] = 5'(vt[n].cdt); rv[0] = 1'(vt[n].rtv); rtg[0] = 5'(vt[n].rtt);
            settle_check();
            chk($sformatf("vec%0d rs1_tag", n), rs1_tag[9:5], vt[n].e_tag);
            chk($sformatf("vec%0d rs1_ready", n), rs1_ready[1], vt[n].e_rdy);
            edge_check();
            chk($sformatf("vec%0d entry", n), dbg[vt[n].idx*6 +: 6], vt[n].e_ent);
        end
        do_reset();
        clear_in(); wr(0, 1, 1); lbr[0] = 1; settle_check(); chk("id A", ckpt_id, 0); edge_check();
        clear_in(); wr(0, 1, 2); lv[1] = 1; lbr[1] = 1; settle_check(); chk("id B", ckpt_id, 1); edge_check();
        clear_in(); wr(0, 1, 3); lv[1] = 1; lbr[1] = 1; settle_check(); chk("id C", ckpt_id, 2); edge_check();
        clear_in(); lv[0] = 1; lbr[0] = 1; wr(1, 1, 4); settle_check(); chk("id D", ckpt_id, 3); edge_check();
        chk("fill count", ckpt_count, 4); chk("fill full", ckpt_full, 1); chk("fill id wrap", ckpt_id, 0);
        chk("fill x1", dbg[11:6], 8);
        clear_in(); bv = 1; bc = 0; cycle();
        chk("resolve count", ckpt_count, 3); chk("resolve full", ckpt_full, 0); chk("resolve id", ckpt_id, 0);
        clear_in(); bv = 1; bm = 1; bc = 2; wr(0, 1, 9); lbr[0] = 1; cycle();
        chk("mp x1", dbg[11:6], 6); chk("mp count", ckpt_count, 1); chk("mp tail", ckpt_id, 2); chk("mp full", ckpt_full, 0);
        clear_in(); lv[0] = 1; lbr[0] = 1; cycle(); chk("live alloc count", ckpt_count, 2);
        clear_in(); cv[1] = 1; ct[1] = 3; cycle(); chk("live cdb x1", dbg[11:6], 7);
        clear_in(); wr(0, 1, 7); cycle(); chk("live overwrite x1", dbg[11:6], 14);
        clear_in(); bv = 1; bm = 1; bc = 2; cycle();
        chk("live restore x1", dbg[11:6], 7); chk("live restore count", ckpt_count, 1);
        clear_in(); wr(0, 5, 3); lbr[0] = 1; cycle(); chk("pre-rst count", ckpt_count, 2); chk("pre-rst x5", dbg[35:30], 6);
        clear_in();
        #1 rst_n = 0;
        #1;
        chk("async rst table", dbg == '0 ? 1 : 0, 1);
        chk("async rst count", ckpt_count, 0); chk("async rst full", ckpt_full, 0); chk("async rst id", ckpt_id, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check_state();
        for (int n = 0; n < 400; n++) begin
            clear_in();
            for (int k = 0; k < 2; k++) begin
                lv[k] = 1'($urandom_range(0, 3) != 0); lhd[k] = 1'($urandom_range(0, 1));
                ld[k] = 5'($urandom_range(0, 7)); lt[k] = 5'($urandom_range(1, 15));
                r1v[k] = 1'($urandom_range(0, 1)); r1[k] = 5'($urandom_range(0, 7));
                r2v[k] = 1'($urandom_range(0, 1)); r2[k] = 5'($urandom_range(0, 7));
                cv[k] = 1'($urandom_range(0, 1)); ct[k] = 5'($urandom_range(0, 15));
                rv[k] = 1'($urandom_range(0, 3) == 0); rtg[k] = 5'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 2) == 0 && live.size() < 4) begin
                int b = $urandom_range(0, 1);
                lv[b] = 1; lbr[b] = 1;
            end
            if (live.size() > 0) begin
                int r = $urandom_range(0, 9);
                if (r < 2) begin bv = 1; bc = 2'(live[0]); end
                else if (r == 2) begin bv = 1; bm = 1; bc = 2'(live[$urandom_range(0, live.size() - 1)]); end
            end
            cycle();
        end
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/map_table_ckpt.md
Name: map_table_ckpt

Overview:
- Superscalar successor to the single-dispatch register map table.
- Maps each architectural register to the ROB tag of its youngest in-flight producer, plus a ready (t_plus) bit.
- Serves DISPATCH_WIDTH instructions per cycle, absorbs CDB_WIDTH broadcasts and RETIRE_WIDTH retirements per cycle.
- Holds a circular queue of NUM_CKPT branch checkpoints for single-cycle mispredict recovery. Sits between dispatch, RS/ROB, CDB and the branch unit.

Parameters:
- DISPATCH_WIDTH, 2, instructions renamed per cycle
- CDB_WIDTH, 2, completion broadcasts per cycle
- RETIRE_WIDTH, 2, ROB retirements per cycle
- NUM_CKPT, 4, branch checkpoints (power of 2, ≥2)
- TAG_W, 5, ROB tag width; tag 0 means "no mapping, value in regfile"

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- dp_valid  in  DISPATCH_WIDTH  lane holds a dispatching instruction; lanes are in program order, lane 0 oldest
- dp_has_dest  in  DISPATCH_WIDTH  lane writes a destination
- dp_dest_idx  in  DISPATCH_WIDTH*5  destination architectural register
- dp_tag  in  DISPATCH_WIDTH*TAG_W  ROB tag allocated to the lane
- dp_is_branch  in  DISPATCH_WIDTH  lane needs a checkpoint; at most one per cycle
- dp_rs1_valid, dp_rs2_valid  in  DISPATCH_WIDTH each  source operand used
- dp_rs1_idx, dp_rs2_idx  in  DISPATCH_WIDTH*5 each  source architectural register
- cdb_valid  in  CDB_WIDTH  broadcast valid
- cdb_tag  in  CDB_WIDTH*TAG_W  completing ROB tag
- rt_valid  in  RETIRE_WIDTH  retirement valid
- rt_tag  in  RETIRE_WIDTH*TAG_W  retiring ROB tag
- br_valid  in  1  branch resolved this cycle
- br_ckpt  in  log2(NUM_CKPT)  checkpoint id of the resolved branch
- br_mispredict  in  1  resolved branch mispredicted
- rs1_tag, rs2_tag  out  DISPATCH_WIDTH*TAG_W each  renamed source tags, 0 when the source is unused or x0
- rs1_ready, rs2_ready  out  DISPATCH_WIDTH each  t_plus of the source (value in ROB)
- ckpt_id  out  log2(NUM_CKPT)  id given to this cycle's branch (current tail)
- ckpt_full  out  1  no free checkpoint; dispatch must stall branches
- ckpt_count  out  log2(NUM_CKPT)+1  live checkpoints
- m_table_dbg  out  32*(TAG_W+1)  current table

Behaviour:
- Reset (asynchronous, reset_n=0):
  - all 32 entries go to {tag 0, t_plus 0}; checkpoints are cleared.
  - head=tail=0, ckpt_count=0, ckpt_full=0, ckpt_id=0.
- Source read is combinational. Lane k, source s resolves in this order:
  - The youngest lane j<k with dp_valid, dp_has_dest and dest==s supplies tag=dp_tag[j], ready=0.
  - Otherwise the table entry is used. If any valid cdb_tag equals the entry tag (tag≠0), ready is forced to 1 in the same cycle.
  - An unused source or x0 gives tag 0, ready 0.
- Next state of each entry, highest priority first:
  - (a) mispredict restore;
  - (b) dispatch write: youngest lane wins on same dest; sets the new tag and t_plus=0; writes to x0 are dropped;
  - (c) retire clear: if the entry tag matches any valid rt_tag, set tag=0, t_plus=0;
  - (d) CDB: if the entry tag is nonzero and matches any valid cdb_tag, set t_plus=1.
- Checkpoint allocate: when a valid dp_is_branch lane b is present, no mispredict is asserted and ckpt_full=0:
  - ckpt[tail] captures the table after (c) and (d), with writes from lanes ≤b applied.
  - tail increments modulo NUM_CKPT; count increments.
  - A branch presented while ckpt_full=1 is a protocol violation: ignored, with an assertion in the bench.
- Checkpoints stay live. Every cycle each stored checkpoint applies the same retire-clear (c) and CDB t_plus (d) rules as the table.
- Correct resolve (br_valid, br_mispredict=0): frees the head checkpoint. br_ckpt must equal head; resolves arrive in order.
- Mispredict (br_valid, br_mispredict=1):
  - table ← ckpt[br_ckpt], updated with this cycle's retire and CDB inputs;
  - tail ← br_ckpt; count ← (br_ckpt−head) mod NUM_CKPT, i.e. that checkpoint and all younger ones are freed;
  - all dispatch lanes and any branch allocation this cycle are ignored.
- Same-cycle allocate and correct-resolve leaves count unchanged. The full condition is evaluated on the pre-update count.
- Tag 0 on the CDB or retire ports never matches any entry.

Test Plan:
- Reset mid-run: with entries x5→tag3 and 2 live checkpoints, pull reset_n low asynchronously → all tags 0, ckpt_count=0, ckpt_full=0 before the next edge.
- Intra-group bypass: lane0 writes x7 tag4, lane1 reads rs1=x7 → rs1_tag[1]=4, ready 0; after the edge m_table[7]={4,0}. Both lanes writing x9 (tags 4,5) → x9=5.
- CDB forwarding: x3→tag6 and cdb_tag=6 in the same cycle that a lane reads x3 → rs1_ready=1; next cycle the entry t_plus=1. cdb_tag=0 changes nothing.
- Retire vs dispatch: retire tag2 (mapped to x4) while lane0 writes x4 tag8 → x4={8,0}. Retire tag2 alone → x4={0,0}.
- Checkpoint fill/recover:
  - Allocate 4 branches → ckpt_full=1, ckpt_id wraps to 0.
  - Correct-resolve id0 → count 3.
  - Mispredict id2 → table equals ckpt2 (x1 restored to tag 3), count=1, tail=2, same-cycle dispatch dropped.
- Live checkpoint update: take checkpoint with x1→tag3, then CDB tag3, then mispredict → restored x1={3,1}.
